pokey_serout: RTL
=================

Name: pokey_serout

Overview:
- Serial-output transmitter for the POKEY serial port; it is the sending end of the frame format that the serial-input shift chain receives.
- The CPU-side SEROUT write loads a holding register. The block moves the holding register into a shift register and sends an asynchronous frame on sout: start bit 0, DATA_BITS data bits LSB first, stop bit 1.
- It raises POKEY's "output needed" and "output complete" interrupt requests.
- It runs in the 50 MHz clk domain. All state advances are qualified by the 1.79 MHz edge enable enp and by the bit-rate tick from the audio channel timers.

Parameters:
- DATA_BITS, 8, number of data bits per frame; legal range 5..8.

Ports:
- clk  in  1  system clock, 50 MHz.
- R  in  1  synchronous, active-high reset.
- enp  in  1  one-clk pulse on each rising edge of the 1.79 MHz clock.
- wr_serout  in  1  one-clk write strobe to the SEROUT holding register.
- din  in  DATA_BITS  write data; sampled when wr_serout=1.
- bit_tick  in  1  bit-rate pulse from the channel timer; acted on only when enp=1 in the same clk.
- force_break  in  1  SKCTL bit 7; when 1, sout is held low.
- sout  out  1  serial line, idle high.
- serout_needed  out  1  one-clk pulse when the holding register is transferred into the shift register (IRQ: output needed).
- serout_done  out  1  one-clk pulse when a stop bit completes and the holding register is empty (IRQ: output complete).
- busy  out  1  1 in every state except IDLE.

Behaviour:
Definitions:
- adv = enp & bit_tick.
- Every register updates on posedge clk.
- R has priority over every other input.

Reset (R=1):
- Next clk: state=IDLE, hold_full=0, shift=0, bitcnt=0, line=1.
- Outputs: sout=1 (unless force_break=1), serout_needed=0, serout_done=0, busy=0.
- R mid-frame abandons the frame immediately; sout returns high on the next clk.

Holding register:
- wr_serout=1 loads din and sets hold_full=1.
- A write while hold_full=1 overwrites the held byte; no error flag is raised.

State machine (line is the internal registered line value; sout = line & ~force_break):
- IDLE: line=1. On enp & hold_full: copy hold into shift, clear hold_full, pulse serout_needed, go to WAIT.
- WAIT: line=1; waits for bit alignment. On adv: go to START, line=0.
- START: on adv: line=shift[0], bitcnt=0, go to DATA.
- DATA: on adv:
  - if bitcnt < DATA_BITS-1: shift right, bitcnt+1, line = next bit;
  - otherwise: line=1, go to STOP.
- STOP: on adv:
  - if hold_full: reload shift from hold, clear hold_full, pulse serout_needed, line=0, go to START (back-to-back frame, no idle gap);
  - otherwise: pulse serout_done, go to IDLE.

Timing:
- Each line level lasts exactly one adv interval.
- Frame length is DATA_BITS+2 bit periods after WAIT.

Simultaneous events:
- wr_serout in the same clk as a transfer: the transfer takes the old held value; hold_full stays 1 holding the new din.
- serout_needed and serout_done are never asserted in the same clk.

Boundary conditions:
- adv while in IDLE is ignored.
- bit_tick without enp is ignored.
- force_break does not alter state; frame timing continues underneath it.

Decomposition:
- Shared package pokey_pkg holds:
  - the state encoding localparams (IDLE, WAIT, START, DATA, STOP);
  - IRQ bit indices for SEROUT needed/complete, shared with the IRQST/IRQEN block.
- No sub-module. The shift register and bit counter are inline, and the design is a single FSM of roughly 150-250 lines.

Test Plan:
- Bench setup: bit_tick every 4th enp, DATA_BITS=8.
- Single frame: write din=8'hA5 while idle → serout_needed one clk later on enp. After the next adv, sout sequence is 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each level lasting 4 enp periods. Then serout_done pulses and busy=0.
- Back-to-back: write 8'h3C, then write 8'hC3 during the DATA state → second serout_needed fires at the end of the first stop bit. Start bit follows with no idle bit. Exactly one serout_done, after the second frame.
- Overwrite: write 8'h11 then 8'h22 while hold_full=1 (shift busy) → only 8'h22 is transmitted after the current frame.
- Collision: wr_serout=8'h55 in the same clk as the STOP→START transfer → frame carries the old byte; 8'h55 is sent in the following frame.
- Reset mid-frame: assert R during data bit 3 → next clk sout=1, busy=0, hold_full=0. No serout_done pulse, and no transmission until a new write.
- Break: force_break=1 during a frame → sout=0 throughout. Release at mid-frame → sout resumes the current bit value, and serout_done still pulses at the nominal frame end.

Source files
------------

// File: rtl/pokey_pkg.sv
// Shared POKEY definitions: serial-output FSM encoding and IRQ bit positions
// used by both the SEROUT transmitter and the IRQST/IRQEN block.
package pokey_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } serout_state_e;

  // IRQST/IRQEN bit positions
  localparam int IRQ_SEROUT_DONE   = 3;
  localparam int IRQ_SEROUT_NEEDED = 4;

endpackage

// File: rtl/pokey_serout.sv
// POKEY serial transmitter: SEROUT holding register feeding a shift register
// that sends start / LSB-first data / stop frames at the channel-timer bit rate.
module pokey_serout
  import pokey_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 R,
  input  logic                 enp,
  input  logic                 wr_serout,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 bit_tick,
  input  logic                 force_break,
  output logic                 sout,
  output logic                 serout_needed,
  output logic                 serout_done,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  serout_state_e          state_q, state_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       bitcnt_q, bitcnt_d;
  logic                   hold_full_q, hold_full_d;
  logic                   line_q, line_d;
  logic                   needed_q, needed_d;
  logic                   done_q, done_d;
  logic                   adv;
  logic                   load;

  assign adv = enp & bit_tick;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    line_d      = line_q;
    needed_d    = 1'b0;
    done_d      = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        line_d = 1'b1;
        if (enp && hold_full_q) begin
          load    = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        line_d = 1'b1;
        if (adv) begin
          line_d  = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (adv) begin
          line_d   = shift_q[0];
          bitcnt_d = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (adv) begin
          if (bitcnt_q < LAST_BIT) begin
            shift_d  = shift_q >> 1;
            bitcnt_d = bitcnt_q + CNT_W'(1);
            line_d   = shift_q[1];
          end else begin
            line_d   = 1'b1;
            state_d  = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (adv) begin
          if (hold_full_q) begin
            // back-to-back: next start bit follows the stop bit directly
            load    = 1'b1;
            line_d  = 1'b0;
            state_d = ST_START;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        line_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      shift_d  = hold_q;
      needed_d = 1'b1;
    end

    // a write coinciding with a transfer refills the holding register
    if (wr_serout) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end else if (load) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      line_q      <= 1'b1;
      needed_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      line_q      <= line_d;
      needed_q    <= needed_d;
      done_q      <= done_d;
    end
  end

  assign sout          = line_q & ~force_break;
  assign serout_needed = needed_q;
  assign serout_done   = done_q;
  assign busy          = (state_q != ST_IDLE);

endmodule
